cpu_top: RTL and testbench
==========================

Name: cpu_top

Overview:
- 8-bit single-cycle accumulator CPU, `cpu`, plus a combinational 256x8 instruction ROM, `instr_mem`, wrapped as one block.
- The CPU drives `pc` into the ROM address; the ROM returns `instr` in the same cycle.
- One instruction executes per rising clock edge until HALT is reached.
- `pc`, `acc`, `halted` and `instr` are exported for observation.

Parameters:
- None. The datapath, PC and instruction are fixed at 8 bits. ROM depth is fixed at 256 words.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  output  8  current program counter; also the ROM address.
- acc  output  8  accumulator.
- halted  output  1  high once HALT has executed; sticky until reset.
- instr  output  8  ROM word at address `pc` (combinational).

Behaviour:
- Reset (asynchronous, active-high): pc=0x00, acc=0x00, halted=0 immediately; all three hold while reset is high. Reset mid-program or while halted restarts from address 0.
- ROM: instr = mem[pc], purely combinational, no clock. Unprogrammed words read 0x00 (NOP).
- Instruction format: opcode = instr[7:4]; imm = instr[3:0], zero-extended to 8 bits where used.
- Execution: on each rising clk edge with reset low and halted=0, execute instr. Unless the opcode says otherwise, pc <= pc+1 modulo 256 (0xFF wraps to 0x00). Latency is 1 cycle; results are visible after the edge.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: acc <= {4'h0, imm}.
  - 0x2 ADDI: acc <= acc + imm, mod 256, carry discarded.
  - 0x3 SUBI: acc <= acc - imm, mod 256, borrow discarded.
  - 0x4 ANDI: acc <= acc & imm.
  - 0x5 ORI: acc <= acc | imm.
  - 0x6 XORI: acc <= acc ^ imm.
  - 0x7 SHL: acc <= acc << 1, LSB filled with 0.
  - 0x8 SHR: acc <= acc >> 1, MSB filled with 0.
  - 0x9 JMP: pc <= {4'h0, imm}.
  - 0xA JZ: if acc==0 then pc <= {4'h0, imm}, else pc <= pc+1.
  - 0xB LDH: acc[7:4] <= imm; acc[3:0] unchanged.
  - 0xC-0xE: reserved, executed as NOP.
  - 0xF HALT: halted <= 1; pc and acc unchanged.
- Halted state: once halted=1, pc and acc freeze. instr continues to show the HALT word. Only reset clears it.
- No flags register: JZ tests acc combinationally at execute time.
- Default ROM contents (words 0-8), all other words 0x00:
  - 0: 0x15  LDI 5
  - 1: 0x23  ADDI 3
  - 2: 0x70  SHL
  - 3: 0x31  SUBI 1
  - 4: 0x6F  XORI F
  - 5: 0xA7  JZ 7
  - 6: 0x11  LDI 1 (skipped by the JZ)
  - 7: 0xBA  LDH A
  - 8: 0xFF  HALT

Test Plan:
- Reset behaviour: reset high for 20 ns with clk running at 10 ns period -> pc=0x00, acc=0x00, halted=0, instr=0x15 throughout reset.
- Default program trace: release reset -> after each edge (pc, acc) = (1,05), (2,08), (3,10), (4,0F), (5,00), (7,00) via the taken JZ, then (8,A0). Next edge sets halted=1 with pc=8, acc=A0.
- Halt hold: keep clocking 20 cycles after halt -> pc=8, acc=A0, halted=1, instr=0xFF unchanged.
- Asynchronous reset mid-run: assert reset between edges while pc=3 -> pc, acc and halted clear immediately without a clock edge; after release the trace repeats from 0x15.
- Arithmetic wrap and branch-not-taken (alternate ROM image):
  - LDI 0, SUBI 1 -> acc=FF.
  - ADDI 2 -> acc=01.
  - JZ 0 with acc=01 -> falls through to pc+1.
  - SHL on acc=0x80 -> acc=00.
  - SHR on acc=0x01 -> acc=00.
- PC wrap (image of all NOPs) -> pc counts 0x00..0xFF, then 0x00; halted stays 0. JMP F from address 0 lands at pc=0x0F.

Source files
------------

// File: rtl/cpu_top_if.sv
// cpu_top_if: observation bus carrying the CPU's architectural state and fetched word
interface cpu_top_if;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       halted;
    logic [7:0] instr;
    modport master (output pc, acc, halted, instr);
    modport slave  (input  pc, acc, halted, instr);
endinterface

// File: rtl/cpu_top.sv
// cpu_top: 8-bit single-cycle accumulator CPU with a combinational 256x8 instruction ROM
module instr_mem #(
    parameter logic [2047:0] IMAGE = '0
) (
    input  logic [7:0] addr,
    output logic [7:0] data
);
    assign data = IMAGE[{addr, 3'b000} +: 8];
endmodule

module cpu (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    output logic [7:0] pc,
    output logic [7:0] acc,
    output logic       halted
);
    typedef enum logic {RUNNING, HALTED} state_t;
    state_t     state, state_next;
    logic [7:0] pc_next, acc_next;
    logic [3:0] op;
    logic [7:0] imm;
    assign op     = instr[7:4];
    assign imm    = {4'h0, instr[3:0]};
    assign halted = (state == HALTED);
    // architectural state register; reset restarts the program from address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUNNING;
            pc    <= 8'h00;
            acc   <= 8'h00;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            acc   <= acc_next;
        end
    end
    // decode and execute the current word; everything freezes once halted
    always_comb begin
        state_next = state;
        pc_next    = pc;
        acc_next   = acc;
        if (state == RUNNING) begin
            pc_next = pc + 8'd1;
            case (op)
                4'h1: acc_next = imm;
                4'h2: acc_next = acc + imm;
                4'h3: acc_next = acc - imm;
                4'h4: acc_next = acc & imm;
                4'h5: acc_next = acc | imm;
                4'h6: acc_next = acc ^ imm;
                4'h7: acc_next = {acc[6:0], 1'b0};
                4'h8: acc_next = {1'b0, acc[7:1]};
                4'h9: pc_next = imm;
                4'hA: pc_next = (acc == 8'h00) ? imm : pc + 8'd1;
                4'hB: acc_next = {instr[3:0], acc[3:0]};
                4'hF: begin
                    pc_next    = pc;
                    state_next = HALTED;
                end
                default: ;
            endcase
        end
    end
endmodule

module cpu_top #(
    parameter logic [2047:0] ROM_IMAGE = {1976'h0, 8'hFF, 8'hBA, 8'h11, 8'hA7,
                                          8'h6F, 8'h31, 8'h70, 8'h23, 8'h15}
) (
    input  logic      clk,
    input  logic      reset,
    cpu_top_if.master bus
);
    logic [7:0] pc, acc, instr;
    logic       halted;
    instr_mem #(.IMAGE(ROM_IMAGE)) u_mem (
        .addr (pc),
        .data (instr)
    );
    cpu u_cpu (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .pc     (pc),
        .acc    (acc),
        .halted (halted)
    );
    assign bus.pc     = pc;
    assign bus.acc    = acc;
    assign bus.halted = halted;
    assign bus.instr  = instr;
endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: scoreboard bench for cpu_top over the default program and alternate ROM images
module tb_cpu_top;
    localparam logic [2047:0] IMG_B = {1912'h0, 8'hF0, 8'hE7, 8'hD0, 8'hC3, 8'h65, 8'h59,
                                       8'h46, 8'h1F, 8'h80, 8'h11, 8'h70, 8'hB8, 8'h10,
                                       8'hA0, 8'h22, 8'h31, 8'h10};
    localparam logic [2047:0] IMG_C = '0;
    localparam logic [2047:0] IMG_D = {1920'h0, 8'hFF, 112'h0, 8'h9F};

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    int   passed = 0, total = 0;
    logic [16:0] sb[$];
    logic [16:0] exp_v, got_v;

    logic [16:0] trace_a [8] = '{
        {8'h01, 8'h05, 1'b0}, {8'h02, 8'h08, 1'b0}, {8'h03, 8'h10, 1'b0}, {8'h04, 8'h0F, 1'b0},
        {8'h05, 8'h00, 1'b0}, {8'h07, 8'h00, 1'b0}, {8'h08, 8'hA0, 1'b0}, {8'h08, 8'hA0, 1'b1}};
    logic [16:0] trace_b [17] = '{
        {8'h01, 8'h00, 1'b0}, {8'h02, 8'hFF, 1'b0}, {8'h03, 8'h01, 1'b0}, {8'h04, 8'h01, 1'b0},
        {8'h05, 8'h00, 1'b0}, {8'h06, 8'h80, 1'b0}, {8'h07, 8'h00, 1'b0}, {8'h08, 8'h01, 1'b0},
        {8'h09, 8'h00, 1'b0}, {8'h0A, 8'h0F, 1'b0}, {8'h0B, 8'h06, 1'b0}, {8'h0C, 8'h0F, 1'b0},
        {8'h0D, 8'h0A, 1'b0}, {8'h0E, 8'h0A, 1'b0}, {8'h0F, 8'h0A, 1'b0}, {8'h10, 8'h0A, 1'b0},
        {8'h10, 8'h0A, 1'b1}};

    cpu_top_if bus_a ();
    cpu_top_if bus_b ();
    cpu_top_if bus_c ();
    cpu_top_if bus_d ();

    cpu_top dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    cpu_top #(.ROM_IMAGE(IMG_B)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    cpu_top #(.ROM_IMAGE(IMG_C)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));
    cpu_top #(.ROM_IMAGE(IMG_D)) dut_d (.clk(clk), .reset(rst_d), .bus(bus_d));

    always #5 clk = ~clk;

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            #7;
            total++;
            if ({bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr} !== {8'h00, 8'h00, 1'b0, 8'h15})
                $display("FAIL reset[%0d]: pc=%h acc=%h halted=%b instr=%h, required 00 00 0 15",
                         i, bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr);
            else passed++;
            #3;
        end
        rst_a = 1'b0;
    endtask

    task automatic test_default_trace(input string tag);
        for (int i = 0; i < 8; i++) sb.push_back(trace_a[i]);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            got_v = {bus_a.pc, bus_a.acc, bus_a.halted};
            total++;
            if (got_v !== exp_v)
                $display("FAIL %s step %0d: pc/acc/halted=%h/%h/%b, required %h/%h/%b",
                         tag, i, got_v[16:9], got_v[8:1], got_v[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            else passed++;
        end
    endtask

    task automatic test_halt_hold;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr} !== {8'h08, 8'hA0, 1'b1, 8'hFF})
                $display("FAIL halt_hold[%0d]: pc=%h acc=%h halted=%b instr=%h, required 08 A0 1 FF",
                         i, bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr);
            else passed++;
        end
    endtask

    task automatic test_async_reset;
        rst_a = 1'b1;
        #1;
        rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_a.pc, bus_a.acc} !== {8'h03, 8'h10})
            $display("FAIL pre_reset: pc=%h acc=%h, required 03 10", bus_a.pc, bus_a.acc);
        else passed++;
        #2;
        rst_a = 1'b1;
        #1;
        total++;
        if ({bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr} !== {8'h00, 8'h00, 1'b0, 8'h15})
            $display("FAIL async_clear: pc=%h acc=%h halted=%b instr=%h, required 00 00 0 15",
                     bus_a.pc, bus_a.acc, bus_a.halted, bus_a.instr);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({bus_a.pc, bus_a.acc, bus_a.halted} !== {8'h00, 8'h00, 1'b0})
            $display("FAIL reset_hold: pc=%h acc=%h halted=%b, required 00 00 0",
                     bus_a.pc, bus_a.acc, bus_a.halted);
        else passed++;
        rst_a = 1'b0;
        test_default_trace("retrace");
    endtask

    task automatic test_arith;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int i = 0; i < 17; i++) sb.push_back(trace_b[i]);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            got_v = {bus_b.pc, bus_b.acc, bus_b.halted};
            total++;
            if (got_v !== exp_v)
                $display("FAIL arith step %0d: pc/acc/halted=%h/%h/%b, required %h/%h/%b",
                         i, got_v[16:9], got_v[8:1], got_v[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            else passed++;
        end
    endtask

    task automatic test_pc_wrap;
        @(posedge clk);
        #1;
        rst_c = 1'b0;
        for (int i = 0; i < 256; i++) begin
            sb.push_back({8'(i + 1), 8'h00, 1'b0});
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            got_v = {bus_c.pc, bus_c.acc, bus_c.halted};
            total++;
            if (got_v !== exp_v)
                $display("FAIL pc_wrap step %0d: pc/acc/halted=%h/%h/%b, required %h/%h/%b",
                         i, got_v[16:9], got_v[8:1], got_v[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            else passed++;
        end
    endtask

    task automatic test_jmp;
        @(posedge clk);
        #1;
        rst_d = 1'b0;
        sb.push_back({8'h0F, 8'h00, 1'b0});
        sb.push_back({8'h0F, 8'h00, 1'b1});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            got_v = {bus_d.pc, bus_d.acc, bus_d.halted};
            total++;
            if (got_v !== exp_v)
                $display("FAIL jmp step %0d: pc/acc/halted=%h/%h/%b, required %h/%h/%b",
                         i, got_v[16:9], got_v[8:1], got_v[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_default_trace("trace");
        test_halt_hold();
        test_async_reset();
        test_arith();
        test_pc_wrap();
        test_jmp();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
